// File: rtl/uart_receiver.sv
// UART receive stage: synchronizes the serial line, recovers start/data/parity/stop
// bits at mid-bit, and reports each completed frame with a one-cycle strobe and error flags.
module uart_receiver #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    input  logic                  parity_enable,
    output logic [DATA_WIDTH-1:0] rx_data_out,
    output logic                  rx_data_valid,
    output logic                  parity_error,
    output logic                  framing_error,
    output logic                  rx_busy
);

    localparam int H  = CLKS_PER_BIT / 2;
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int CW = $clog2(DATA_WIDTH + 1);

    localparam logic [TW-1:0] HALF_LAST = TW'(H - 1);
    localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic                    rx_meta;
    logic                    rx_s;
    logic                    rx_prev;
    logic [TW-1:0]           timer;
    logic [CW-1:0]           bit_idx;
    logic [DATA_WIDTH-1:0]   shift;
    logic                    par_en;
    logic                    par_bit;

    logic                    start_det;
    logic                    timer_clear;
    logic                    shift_en;
    logic                    par_sample;
    logic                    frame_done;

    function automatic logic even_parity(input logic [DATA_WIDTH-1:0] d);
        return ^d;
    endfunction

    // Line synchronizer; idle-high reset so a released reset never looks like a start edge
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx_in;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    always_comb begin
        state_next  = state;
        start_det   = 1'b0;
        timer_clear = 1'b0;
        shift_en    = 1'b0;
        par_sample  = 1'b0;
        frame_done  = 1'b0;
        case (state)
            IDLE: begin
                timer_clear = 1'b1;
                if (!rx_s && rx_prev) begin
                    start_det  = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                if (timer == HALF_LAST) begin
                    timer_clear = 1'b1;
                    state_next  = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (timer == BIT_LAST) begin
                    timer_clear = 1'b1;
                    shift_en    = 1'b1;
                    if (bit_idx == DATA_LAST) begin
                        state_next = par_en ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (timer == BIT_LAST) begin
                    timer_clear = 1'b1;
                    par_sample  = 1'b1;
                    state_next  = STOP;
                end
            end
            STOP: begin
                // Returning to IDLE at mid-stop lets the next start edge be caught immediately
                if (timer == BIT_LAST) begin
                    timer_clear = 1'b1;
                    frame_done  = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            timer         <= '0;
            bit_idx       <= '0;
            shift         <= '0;
            par_en        <= 1'b0;
            par_bit       <= 1'b0;
            rx_data_out   <= '0;
            rx_data_valid <= 1'b0;
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            state         <= state_next;
            timer         <= timer_clear ? '0 : timer + 1'b1;
            rx_data_valid <= frame_done;
            if (start_det) begin
                par_en  <= parity_enable;
                bit_idx <= '0;
            end
            if (shift_en) begin
                shift   <= {rx_s, shift[DATA_WIDTH-1:1]};
                bit_idx <= bit_idx + 1'b1;
            end
            if (par_sample) begin
                par_bit <= rx_s;
            end
            if (frame_done) begin
                rx_data_out   <= shift;
                parity_error  <= par_en && (par_bit != even_parity(shift));
                framing_error <= ~rx_s;
            end
        end
    end

    assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Scenario bench for uart_receiver: expected frames are queued as they are sent and
// matched against strobes captured by a passive monitor.
module tb_uart_receiver;

    localparam int DW  = 8;
    localparam int CPB = 16;

    typedef struct packed {
        logic [7:0] data;
        logic       pe;
        logic       fe;
        int         lat;
    } frame_t;

    logic          clk;
    logic          rst;
    logic          rx_in;
    logic          parity_enable;
    logic [DW-1:0] rx_data_out;
    logic          rx_data_valid;
    logic          parity_error;
    logic          framing_error;
    logic          rx_busy;

    int vectors;
    int fails;
    int cyc;
    int start_cyc;
    logic busy_d;

    frame_t exp_q[$];
    frame_t cap_q[$];
    int     cyc_q[$];

    uart_receiver #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB)) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_in         (rx_in),
        .parity_enable (parity_enable),
        .rx_data_out   (rx_data_out),
        .rx_data_valid (rx_data_valid),
        .parity_error  (parity_error),
        .framing_error (framing_error),
        .rx_busy       (rx_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Passive capture: latency is measured from the rx_busy rise (START entry)
    initial begin
        busy_d    = 1'b0;
        start_cyc = 0;
    end
    always @(negedge clk) begin
        if (rx_busy && !busy_d) start_cyc <= cyc;
        busy_d <= rx_busy;
        if (rx_data_valid) begin
            cap_q.push_back('{data: rx_data_out, pe: parity_error, fe: framing_error,
                              lat: cyc - start_cyc});
            cyc_q.push_back(cyc);
        end
    end

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        rx_in = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx_in = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit,
                              input logic stop, input bit push);
        frame_t e;
        parity_enable = pen;
        if (push) begin
            e.data = d;
            e.pe   = pen && (pbit != ^d);
            e.fe   = ~stop;
            e.lat  = pen ? 168 : 152;
            exp_q.push_back(e);
        end
        drive_bit(1'b0);
        for (int k = 0; k < DW; k++) drive_bit(d[k]);
        if (pen) drive_bit(pbit);
        drive_bit(stop);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx_in = 1'b1;
        parity_enable = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({rx_data_out, rx_data_valid, parity_error, framing_error, rx_busy} !== 12'h000) begin
            fails++;
            $display("FAIL reset_outputs: got data=%h vld=%b pe=%b fe=%b busy=%b, required all 0",
                     rx_data_out, rx_data_valid, parity_error, framing_error, rx_busy);
        end
        align();
        rst = 1'b0;
        idle(40);
        vectors++;
        if (cap_q.size() != 0 || rx_busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle: got strobes=%0d busy=%b, required 0 and 0",
                     cap_q.size(), rx_busy);
            cap_q.delete();
            cyc_q.delete();
        end
    endtask

    task automatic test_clean();
        frame_t e, g;
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(32);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (cap_q.size() == 0) begin
                fails++;
                $display("FAIL clean: got no strobe, required data=%h", e.data);
            end else begin
                g = cap_q.pop_front();
                void'(cyc_q.pop_front());
                if (g !== e) begin
                    fails++;
                    $display("FAIL clean: got data=%h pe=%b fe=%b lat=%0d, required data=%h pe=%b fe=%b lat=%0d",
                             g.data, g.pe, g.fe, g.lat, e.data, e.pe, e.fe, e.lat);
                end
            end
        end
        vectors++;
        if (cap_q.size() != 0) begin
            fails++;
            $display("FAIL clean_extra: got %0d extra strobes, required 0", cap_q.size());
            cap_q.delete();
            cyc_q.delete();
        end
    endtask

    task automatic test_parity();
        frame_t e, g;
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1);
        idle(32);
        send_frame(8'h01, 1'b1, 1'b0, 1'b1, 1'b1);
        idle(32);
        parity_enable = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (cap_q.size() == 0) begin
                fails++;
                $display("FAIL parity: got no strobe, required data=%h", e.data);
            end else begin
                g = cap_q.pop_front();
                void'(cyc_q.pop_front());
                if (g !== e) begin
                    fails++;
                    $display("FAIL parity: got data=%h pe=%b fe=%b lat=%0d, required data=%h pe=%b fe=%b lat=%0d",
                             g.data, g.pe, g.fe, g.lat, e.data, e.pe, e.fe, e.lat);
                end
            end
        end
        vectors++;
        if (cap_q.size() != 0) begin
            fails++;
            $display("FAIL parity_extra: got %0d extra strobes, required 0", cap_q.size());
            cap_q.delete();
            cyc_q.delete();
        end
    endtask

    task automatic test_framing_break();
        frame_t e, g;
        send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 40; i++) drive_bit(1'b0);
        vectors++;
        if (cap_q.size() != 1) begin
            fails++;
            $display("FAIL break_hold: got %0d strobes during break, required 1", cap_q.size());
        end
        idle(32);
        send_frame(8'h0F, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(32);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (cap_q.size() == 0) begin
                fails++;
                $display("FAIL framing: got no strobe, required data=%h", e.data);
            end else begin
                g = cap_q.pop_front();
                void'(cyc_q.pop_front());
                if (g !== e) begin
                    fails++;
                    $display("FAIL framing: got data=%h pe=%b fe=%b lat=%0d, required data=%h pe=%b fe=%b lat=%0d",
                             g.data, g.pe, g.fe, g.lat, e.data, e.pe, e.fe, e.lat);
                end
            end
        end
        vectors++;
        if (cap_q.size() != 0) begin
            fails++;
            $display("FAIL framing_extra: got %0d extra strobes, required 0", cap_q.size());
            cap_q.delete();
            cyc_q.delete();
        end
    endtask

    task automatic test_glitch_abort();
        frame_t e, g;
        rx_in = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        idle(48);
        vectors++;
        if (cap_q.size() != 0 || rx_busy !== 1'b0) begin
            fails++;
            $display("FAIL glitch: got strobes=%0d busy=%b, required 0 and 0", cap_q.size(), rx_busy);
            cap_q.delete();
            cyc_q.delete();
        end
        parity_enable = 1'b0;
        drive_bit(1'b0);
        for (int k = 0; k < 3; k++) drive_bit(1'b1);
        rx_in = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({rx_data_out, rx_data_valid, parity_error, framing_error, rx_busy} !== 12'h000) begin
            fails++;
            $display("FAIL abort_reset: got data=%h vld=%b pe=%b fe=%b busy=%b, required all 0",
                     rx_data_out, rx_data_valid, parity_error, framing_error, rx_busy);
        end
        align();
        rst = 1'b0;
        idle(200);
        vectors++;
        if (cap_q.size() != 0) begin
            fails++;
            $display("FAIL abort_strobe: got %0d strobes, required 0", cap_q.size());
            cap_q.delete();
            cyc_q.delete();
        end
        send_frame(8'h81, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(32);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (cap_q.size() == 0) begin
                fails++;
                $display("FAIL after_abort: got no strobe, required data=%h", e.data);
            end else begin
                g = cap_q.pop_front();
                void'(cyc_q.pop_front());
                if (g !== e) begin
                    fails++;
                    $display("FAIL after_abort: got data=%h pe=%b fe=%b lat=%0d, required data=%h pe=%b fe=%b lat=%0d",
                             g.data, g.pe, g.fe, g.lat, e.data, e.pe, e.fe, e.lat);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        frame_t e, g;
        int c;
        int prev_c;
        int n;
        send_frame(8'h12, 1'b0, 1'b0, 1'b1, 1'b1);
        send_frame(8'h34, 1'b0, 1'b0, 1'b1, 1'b1);
        send_frame(8'h56, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(40);
        n = 0;
        prev_c = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (cap_q.size() == 0) begin
                fails++;
                $display("FAIL b2b: got no strobe, required data=%h", e.data);
            end else begin
                g = cap_q.pop_front();
                c = cyc_q.pop_front();
                if (g !== e) begin
                    fails++;
                    $display("FAIL b2b: got data=%h pe=%b fe=%b lat=%0d, required data=%h pe=%b fe=%b lat=%0d",
                             g.data, g.pe, g.fe, g.lat, e.data, e.pe, e.fe, e.lat);
                end
                if (n > 0) begin
                    vectors++;
                    if (c - prev_c != 160) begin
                        fails++;
                        $display("FAIL b2b_spacing: got %0d clocks between strobes, required 160", c - prev_c);
                    end
                end
                prev_c = c;
                n++;
            end
        end
        vectors++;
        if (cap_q.size() != 0) begin
            fails++;
            $display("FAIL b2b_extra: got %0d extra strobes, required 0", cap_q.size());
            cap_q.delete();
            cyc_q.delete();
        end
    endtask

    initial begin
        vectors = 0;
        fails   = 0;
        rst     = 1'b1;
        rx_in   = 1'b1;
        parity_enable = 1'b0;
        test_reset();
        test_clean();
        test_parity();
        test_framing_break();
        test_glitch_abort();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel UART receive stage that consumes the line driven by the team's UART transmitter (start bit 0, data LSB-first, optional even-parity bit, stop bit 1). It oversamples the asynchronous line with the system clock, recovers each frame with a state machine, and presents the byte with a one-cycle valid strobe plus parity and framing error flags to the APB-side register logic.

## Interface

Parameters:
- DATA_WIDTH, 8, data bits per frame.
- CLKS_PER_BIT, 16, system clocks per bit period; even, ≥ 4. H = CLKS_PER_BIT/2.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- rx_in  input  1  asynchronous serial line, idle high.
- parity_enable  input  1  1 = frame carries an even-parity bit after the data.
- rx_data_out  output  DATA_WIDTH  last received data word.
- rx_data_valid  output  1  one-cycle strobe, new frame completed.
- parity_error  output  1  parity mismatch on the completed frame.
- framing_error  output  1  stop bit sampled as 0 on the completed frame.
- rx_busy  output  1  high whenever state ≠ IDLE.

## Operation

- Two-flop synchronizer on rx_in gives rx_s; a third flop gives rx_prev. Synchronizer and rx_prev flops reset to 1.
- Start detection: in IDLE, a falling edge (rx_s==0 && rx_prev==1) moves to START, clears the bit-timer, and latches parity_enable for the frame. A held-low line never re-triggers; rx_s must return to 1 first.
- States and transitions:
  - IDLE → START on a falling edge.
  - START: sample rx_s at mid-bit. 0 → DATA. 1 → IDLE (glitch rejected, no strobe).
  - DATA: sample rx_s every CLKS_PER_BIT clocks. Bit k goes to shift position k, LSB first. After DATA_WIDTH samples, go to PARITY if latched parity_enable, else to STOP.
  - PARITY: sample one bit. Expected value = ^data (even parity).
  - STOP: sample one bit, then return to IDLE on the same edge. Re-arming mid-stop-bit allows back-to-back frames.
- At the stop-sample edge, the completed frame updates these registers:
  - rx_data_out ← received data. Updated even when an error is flagged.
  - parity_error ← (latched enable && sampled parity ≠ ^data).
  - framing_error ← (stop sample == 0).
  - rx_data_valid ← 1.
- rx_data_valid deasserts the following cycle.
- parity_error and framing_error hold their values until the next frame completion.
- Reset behaviour: rst at any time, including mid-frame, returns the block to IDLE. All outputs and shift register go to 0. The aborted frame produces no strobe.

## Timing

- Edge 0 is the clock edge at which the FSM enters START.
- rx_s lags rx_in by 2 clock edges.
- Sample edges:
  - Start: edge H.
  - Data bit k (k = 0..DATA_WIDTH−1): edge H + (k+1)·CLKS_PER_BIT.
  - Parity: edge H + (DATA_WIDTH+1)·CLKS_PER_BIT.
  - Stop: edge H + (DATA_WIDTH+1+P)·CLKS_PER_BIT, where P = latched parity_enable.
- rx_data_valid is high for exactly one cycle, immediately after the stop-sample edge.
- Defaults, no parity: stop sample at edge 152, strobe during cycle 152→153. With parity: stop sample at edge 168.
- rx_busy is high from edge 0 until the stop-sample edge.
- No flow control: a new frame overwrites rx_data_out whether or not the previous one was consumed.
- Bit-timer width is ceil(log2(CLKS_PER_BIT)).
- Bit index counter width is ceil(log2(DATA_WIDTH+1)).

## Test plan

All scenarios use defaults (DATA_WIDTH=8, CLKS_PER_BIT=16). Bits are driven for 16 clocks each.

- Reset: hold rst for 3 cycles with rx_in=1 → all outputs 0, rx_busy 0; no strobe while the line stays idle.
- Clean frame, parity off: send 0xA5 → one rx_data_valid pulse at edge 152 after START entry; rx_data_out=0xA5; both error flags 0.
- Parity on, correct and wrong: send 0x3C with parity 0 → valid, parity_error=0. Then send 0x01 with parity 0 → rx_data_out=0x01, parity_error=1.
- Framing error and break: send 0x55 with stop bit 0 → framing_error=1 with the strobe. Hold the line low for 40 more bit times → no further strobes until rx_in returns high and falls again.
- Glitch and reset abort:
  - Pulse rx_in low for 4 clocks (< H) → FSM returns to IDLE, no strobe.
  - Start 0xFF, assert rst mid-data-bit-3 → no strobe, outputs 0.
  - Next frame 0x81 → received correctly.
- Back-to-back: send 0x12, 0x34, 0x56 with no idle gap, stop bit immediately followed by start → three strobes exactly 160 clocks apart with correct data, no errors.
